// File: rtl/interrupt_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer_pkg
// Shared CPU definitions for the interrupt entry path: sequencer state
// encoding, default vector location, the decode-to-memory drain depth and
// the Moore output decode used by the sequencer.
// ---------------------------------------------------------------------------
package interrupt_sequencer_pkg;

    // Instruction-memory word holding the handler pointer.
    localparam int unsigned DEFAULT_VECTOR_ADDR = 0;

    // Unstalled cycles between decode injecting the push and that push
    // reaching memory. Must be kept in step with the pipeline depth.
    localparam int unsigned DRAIN_DEPTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SAFE = 3'd1,
        ST_INJECT    = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_VECTOR    = 3'd4,
        ST_LOAD      = 3'd5,
        ST_SERVICE   = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic interrupt;
        logic flush_fetch;
        logic freeze_pc;
        logic vector_req;
        logic load_pc;
        logic in_service;
    } seq_out_t;

    // Per-state output values; every output is a pure function of state.
    function automatic seq_out_t decode_outputs(input seq_state_e state);
        seq_out_t outs;
        outs = '0;
        case (state)
            ST_WAIT_SAFE: begin
                outs.freeze_pc   = 1'b1;
                outs.flush_fetch = 1'b1;
            end
            ST_INJECT: begin
                outs.interrupt   = 1'b1;
                outs.freeze_pc   = 1'b1;
                outs.flush_fetch = 1'b1;
            end
            ST_DRAIN: begin
                outs.freeze_pc   = 1'b1;
                outs.flush_fetch = 1'b1;
            end
            ST_VECTOR: begin
                outs.vector_req  = 1'b1;
                outs.freeze_pc   = 1'b1;
                outs.flush_fetch = 1'b1;
            end
            ST_LOAD: begin
                outs.load_pc     = 1'b1;
                outs.flush_fetch = 1'b1;
            end
            ST_SERVICE: outs.in_service = 1'b1;
            default:    outs = '0;
        endcase
        return outs;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_drain_counter.sv
// ---------------------------------------------------------------------------
// drain_counter
// Loadable down-counter with enable and zero flag. Saturates at zero.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (count -> 0)
//   i_load           load i_load_value (has priority over i_en)
//   i_load_value     value to load
//   i_en             decrement by one when nonzero
//   o_count          current count
//   o_zero           count equals zero
// ---------------------------------------------------------------------------
module drain_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: always_comb assigns a default before any branch so no path leaves
    // count_d unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_zero  = (count_q == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer
// Latches external interrupt requests, waits for a safe pipeline point,
// strobes decode to push PC+flags, freezes fetch while the push drains,
// fetches the handler pointer from the vector and loads it into the PC.
// Nested interrupts are held pending until the handler's RTI retires.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_int_req             external interrupt request (level)
//   i_stall               pipeline stall from hazard unit
//   i_hazard_in_flight    control-flow / LDM instruction in decode or execute
//   i_rti_retired         RTI finished its PC pop this cycle
//   i_vector_valid/data   vector read response
//   o_interrupt           one-cycle strobe into decode
//   o_flush_fetch         replace fetched word with NOP
//   o_freeze_pc           hold PC register
//   o_vector_req/addr     vector read request and constant address
//   o_load_pc/pc_value    load captured handler address into PC
//   o_in_service          handler executing
// All outputs are registered; there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned VECTOR_ADDR  = DEFAULT_VECTOR_ADDR,
    parameter int unsigned DRAIN_CYCLES = DRAIN_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_int_req,
    input  logic                  i_stall,
    input  logic                  i_hazard_in_flight,
    input  logic                  i_rti_retired,
    input  logic                  i_vector_valid,
    input  logic [PC_WIDTH-1:0]   i_vector_data,
    output logic                  o_interrupt,
    output logic                  o_flush_fetch,
    output logic                  o_freeze_pc,
    output logic                  o_vector_req,
    output logic [ADDR_WIDTH-1:0] o_vector_addr,
    output logic                  o_load_pc,
    output logic [PC_WIDTH-1:0]   o_pc_value,
    output logic                  o_in_service
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_e          state_q, state_d;
    logic                pending_q, pending_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    seq_out_t            out_q;

    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_zero;
    logic [CNT_W-1:0]    cnt_value;

    drain_counter #(
        .WIDTH (CNT_W)
    ) u_drain_counter (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (cnt_load),
        .i_load_value (CNT_W'(DRAIN_CYCLES - 1)),
        .i_en         (cnt_en),
        .o_count      (cnt_value),
        .o_zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_WAIT_SAFE;
            end
            ST_WAIT_SAFE: begin
                if (!i_stall && !i_hazard_in_flight) state_d = ST_INJECT;
            end
            ST_INJECT: begin
                cnt_load = 1'b1;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Only unstalled cycles move the push toward memory.
                cnt_en = !i_stall;
                if (cnt_zero && !i_stall) state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                if (i_vector_valid) begin
                    pc_d    = i_vector_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                // Requests only set pending here; RTI is the sole exit.
                if (i_rti_retired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The request is consumed on entry to INJECT; a request in that same
    // cycle keeps it set so it is serviced after the current handler.
    assign pending_d = i_int_req |
                       (pending_q & ~((state_q == ST_WAIT_SAFE) && (state_d == ST_INJECT)));

    // Outputs are registered from the next-state decode, so they line up
    // with state_q and never depend combinationally on inputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            pc_q      <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
            out_q     <= decode_outputs(state_d);
        end
    end

    assign o_interrupt   = out_q.interrupt;
    assign o_flush_fetch = out_q.flush_fetch;
    assign o_freeze_pc   = out_q.freeze_pc;
    assign o_vector_req  = out_q.vector_req;
    assign o_load_pc     = out_q.load_pc;
    assign o_in_service  = out_q.in_service;
    assign o_pc_value    = pc_q;
    assign o_vector_addr = ADDR_WIDTH'(VECTOR_ADDR);

    // Count is observed only through the zero flag.
    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_sequencer
// Directed scenarios for the interrupt sequencer. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled at the same point, so the
// values seen after the k-th step belong to cycle k of a scenario whose
// cycle 0 inputs were driven before the first step.
// ---------------------------------------------------------------------------
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req;
    logic        stall;
    logic        hazard;
    logic        rti;
    logic        vec_valid;
    logic [31:0] vec_data;
    logic        o_interrupt, o_flush_fetch, o_freeze_pc, o_vector_req;
    logic        o_load_pc, o_in_service;
    logic [19:0] o_vector_addr;
    logic [31:0] o_pc_value;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_int_req          (int_req),
        .i_stall            (stall),
        .i_hazard_in_flight (hazard),
        .i_rti_retired      (rti),
        .i_vector_valid     (vec_valid),
        .i_vector_data      (vec_data),
        .o_interrupt        (o_interrupt),
        .o_flush_fetch      (o_flush_fetch),
        .o_freeze_pc        (o_freeze_pc),
        .o_vector_req       (o_vector_req),
        .o_vector_addr      (o_vector_addr),
        .o_load_pc          (o_load_pc),
        .o_pc_value         (o_pc_value),
        .o_in_service       (o_in_service)
    );

    // Output bundle {interrupt, flush, freeze, vector_req, load_pc, in_service}.
    wire [5:0] obs = {o_interrupt, o_flush_fetch, o_freeze_pc,
                      o_vector_req, o_load_pc, o_in_service};

    localparam logic [5:0] E_IDLE  = 6'b000000;
    localparam logic [5:0] E_WAIT  = 6'b011000;
    localparam logic [5:0] E_INJ   = 6'b111000;
    localparam logic [5:0] E_DRAIN = 6'b011000;
    localparam logic [5:0] E_VEC   = 6'b011100;
    localparam logic [5:0] E_LOAD  = 6'b010010;
    localparam logic [5:0] E_SVC   = 6'b000001;

    // Expected outputs for cycle c of a sequence with the given milestones:
    // WAIT_SAFE from wait_c, INJECT at inj_c, VECTOR from vec_c, LOAD at load_c.
    function automatic logic [5:0] exp_seq(input int c, input int wait_c,
                                           input int inj_c, input int vec_c,
                                           input int load_c);
        if (c < wait_c)       return E_IDLE;
        else if (c < inj_c)   return E_WAIT;
        else if (c == inj_c)  return E_INJ;
        else if (c < vec_c)   return E_DRAIN;
        else if (c < load_c)  return E_VEC;
        else if (c == load_c) return E_LOAD;
        else                  return E_SVC;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        int_req   = 1'b0;
        stall     = 1'b0;
        hazard    = 1'b0;
        rti       = 1'b0;
        vec_valid = 1'b0;
        vec_data  = 32'hDEAD_BEEF;
    endtask

    // Retire the handler and let the sequencer settle back in IDLE.
    task automatic finish_handler();
        rti = 1'b1;
        step();
        rti = 1'b0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (obs !== E_IDLE) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
        end
        checks++;
        if (o_pc_value !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc_value: got %h expected 00000000", o_pc_value);
        end
        checks++;
        if (o_vector_addr !== 20'h0) begin
            failures++;
            $display("FAIL vector_addr: got %h expected 00000", o_vector_addr);
        end
    endtask

    // Minimum latency: pending 1, WAIT 2, INJECT 3, DRAIN 4..6, VECTOR 7..8,
    // LOAD 9, SERVICE from 10.
    task automatic test_idle_request();
        logic [5:0] e;
        int_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            int_req = 1'b0;
            e = exp_seq(c, 2, 3, 7, 9);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL idle_request cycle %0d: got %b expected %b", c, obs, e);
            end
            if (c == 9 || c == 11) begin
                checks++;
                if (o_pc_value !== 32'h0000_0120) begin
                    failures++;
                    $display("FAIL idle_request_pc cycle %0d: got %h expected 00000120",
                             c, o_pc_value);
                end
            end
            vec_valid = (c == 8);
            vec_data  = (c == 8) ? 32'h0000_0120 : 32'hDEAD_BEEF;
        end
        finish_handler();
    endtask

    // Hazard held during WAIT_SAFE cycles 2..5 pushes INJECT from 3 to 7.
    task automatic test_hazard_hold();
        logic [5:0] e;
        int strobes = 0;
        int_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            int_req = 1'b0;
            if (o_interrupt === 1'b1) strobes++;
            e = exp_seq(c, 2, 7, 11, 13);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL hazard_hold cycle %0d: got %b expected %b", c, obs, e);
            end
            hazard    = (c >= 2 && c <= 5);
            vec_valid = (c == 12);
            vec_data  = (c == 12) ? 32'h0000_0340 : 32'hDEAD_BEEF;
        end
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL hazard_hold_strobes: got %0d expected 1", strobes);
        end
        checks++;
        if (o_pc_value !== 32'h0000_0340) begin
            failures++;
            $display("FAIL hazard_hold_pc: got %h expected 00000340", o_pc_value);
        end
        finish_handler();
    endtask

    // Stall in DRAIN cycles 5 and 6 moves VECTOR from 7 to 9; leaves the
    // sequencer in SERVICE for the next scenario.
    task automatic test_stall_in_drain();
        logic [5:0] e;
        int strobes = 0;
        int_req = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            int_req = 1'b0;
            if (o_interrupt === 1'b1) strobes++;
            e = exp_seq(c, 2, 3, 9, 11);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL stall_in_drain cycle %0d: got %b expected %b", c, obs, e);
            end
            stall     = (c == 5 || c == 6);
            vec_valid = (c == 10);
            vec_data  = (c == 10) ? 32'h0000_0560 : 32'hDEAD_BEEF;
        end
        checks++;
        if (strobes != 1) begin
            failures++;
            $display("FAIL stall_in_drain_strobes: got %0d expected 1", strobes);
        end
    endtask

    // Request during SERVICE stays pending; after RTI (cycle 0) the
    // sequencer is IDLE at 1, WAIT_SAFE at 2 and injects at 3.
    task automatic test_no_nesting();
        logic [5:0] e;
        int_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            int_req = 1'b0;
            checks++;
            if (obs !== E_SVC) begin
                failures++;
                $display("FAIL no_nesting_hold cycle %0d: got %b expected %b", k, obs, E_SVC);
            end
        end
        rti = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            rti = 1'b0;
            e = exp_seq(c, 1, 3, 7, 9);
            if (c == 1) e = E_IDLE;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL no_nesting_second cycle %0d: got %b expected %b", c, obs, e);
            end
            vec_valid = (c == 8);
            vec_data  = (c == 8) ? 32'h0000_0780 : 32'hDEAD_BEEF;
        end
        checks++;
        if (o_pc_value !== 32'h0000_0780) begin
            failures++;
            $display("FAIL no_nesting_pc: got %h expected 00000780", o_pc_value);
        end
    endtask

    // RTI and a request together in SERVICE: IDLE, then WAIT_SAFE, then
    // INJECT. The sequence is then abandoned by reset.
    task automatic test_rti_with_req();
        logic [5:0] e;
        rti     = 1'b1;
        int_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            rti     = 1'b0;
            int_req = 1'b0;
            e = (c == 1) ? E_IDLE : ((c == 2) ? E_WAIT : E_INJ);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL rti_with_req cycle %0d: got %b expected %b", c, obs, e);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Reset in VECTOR (cycle 7) with a request pending from cycle 5 and a
    // valid response arriving during and after reset: everything stays 0.
    task automatic test_reset_mid_vector();
        logic [5:0] e;
        int_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            int_req = (c == 5);
            if (c <= 7) e = exp_seq(c, 2, 3, 7, 9);
            else        e = E_IDLE;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_mid_vector cycle %0d: got %b expected %b", c, obs, e);
            end
            if (c >= 8) begin
                checks++;
                if (o_pc_value !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_mid_vector_pc cycle %0d: got %h expected 00000000",
                             c, o_pc_value);
                end
            end
            reset     = (c == 7);
            vec_valid = (c == 7 || c == 8);
            vec_data  = 32'h0000_0ABC;
        end
        vec_valid = 1'b0;
    endtask

    task automatic test_spurious_rti();
        rti = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            rti = (c < 3);
            checks++;
            if (obs !== E_IDLE) begin
                failures++;
                $display("FAIL spurious_rti cycle %0d: got %b expected %b", c, obs, E_IDLE);
            end
        end
        rti = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_request();
        test_hazard_hold();
        test_stall_in_drain();
        test_no_nesting();
        test_rti_with_req();
        test_reset_mid_vector();
        test_spurious_rti();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
